// File: rtl/expr_pkg.sv
// Shared encodings for the expression checker.
//   state_t : FSM states (2-bit)
//   cls_t   : character classes produced by char_class
//   E_*     : error codes reported on err_code
package expr_pkg;

    typedef enum logic [1:0] {
        S_OPND  = 2'd0,  // expecting an operand
        S_NUM   = 2'd1,  // inside a number
        S_CLOSE = 2'd2,  // just after ')'
        S_ERR   = 2'd3   // sticky error
    } state_t;

    typedef enum logic [2:0] {
        C_DIG = 3'd0,
        C_OP  = 3'd1,
        C_LP  = 3'd2,
        C_RP  = 3'd3,
        C_ILL = 3'd4
    } cls_t;

    localparam logic [2:0] E_NONE         = 3'd0;
    localparam logic [2:0] E_ILLEGAL      = 3'd1;
    localparam logic [2:0] E_TOO_LONG     = 3'd2;
    localparam logic [2:0] E_UNMATCHED_RP = 3'd3;
    localparam logic [2:0] E_DEPTH_OVF    = 3'd4;
    localparam logic [2:0] E_MISSING_OPND = 3'd5;
    localparam logic [2:0] E_DIG_AFTER_RP = 3'd6;

endpackage

// File: rtl/expr_check_n_char_class.sv
// Combinational ASCII classifier for the expression checker.
//   i_char : ASCII byte
//   o_cls  : DIG / OP / LP / RP / ILL
// '-' and '/' count as operators only when EXT_OPS is non-zero.
module char_class
    import expr_pkg::*;
#(
    parameter int EXT_OPS = 0
) (
    input  logic [7:0] i_char,
    output cls_t       o_cls
);

    always_comb begin
        o_cls = C_ILL;
        if (i_char >= 8'h30 && i_char <= 8'h39)
            o_cls = C_DIG;
        else if (i_char == 8'h2B || i_char == 8'h2A)           // '+' '*'
            o_cls = C_OP;
        else if (EXT_OPS != 0 && (i_char == 8'h2D || i_char == 8'h2F)) // '-' '/'
            o_cls = C_OP;
        else if (i_char == 8'h28)                             // '('
            o_cls = C_LP;
        else if (i_char == 8'h29)                             // ')'
            o_cls = C_RP;
    end

endmodule

// File: rtl/expr_check_n.sv
// Streaming validator for arithmetic expressions, one ASCII byte per
// accepted cycle.
//   clk, clr_n  : clock, async active-low reset
//   restart     : sync restart (beats in_valid)
//   in_valid,in : character strobe and byte
//   out         : consumed chars form a complete balanced expression
//   err/err_code/err_pos : sticky error, cause, 0-based offending index
//   depth       : open-parenthesis count
//   char_cnt    : accepted chars, saturating
module expr_check_n
    import expr_pkg::*;
#(
    parameter int MAX_DEPTH  = 15,
    parameter int MAX_DIGITS = 1,
    parameter int EXT_OPS    = 0,
    parameter int POS_W      = 16,
    localparam int DEPTH_W   = $clog2(MAX_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               restart,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [2:0]         err_code,
    output logic [POS_W-1:0]   err_pos,
    output logic [DEPTH_W-1:0] depth,
    output logic [POS_W-1:0]   char_cnt
);

    localparam int DIG_W = $clog2(MAX_DIGITS + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(MAX_DEPTH);
    localparam logic [DIG_W-1:0]   DIG_MAX   = DIG_W'(MAX_DIGITS);

    state_t             r_state;
    logic [DEPTH_W-1:0] r_depth;
    logic [DIG_W-1:0]   r_dcnt;
    logic [POS_W-1:0]   r_cnt;
    logic [POS_W-1:0]   r_pos;
    logic               r_err;
    logic [2:0]         r_code;

    cls_t               w_cls;
    state_t             w_nstate;
    logic [DEPTH_W-1:0] w_ndepth;
    logic [DIG_W-1:0]   w_ndcnt;
    logic [2:0]         w_code;

    char_class #(.EXT_OPS(EXT_OPS)) u_cls (
        .i_char (in),
        .o_cls  (w_cls)
    );

    // Next-state decode for a consumed character; w_code != E_NONE
    // means the character is rejected and nothing but the error fields move.
    always_comb begin
        w_nstate = r_state;
        w_ndepth = r_depth;
        w_ndcnt  = r_dcnt;
        w_code   = E_NONE;
        case (r_state)
            S_OPND: begin
                case (w_cls)
                    C_DIG: begin
                        w_nstate = S_NUM;
                        w_ndcnt  = DIG_W'(1);
                    end
                    C_LP: begin
                        if (r_depth == DEPTH_MAX) w_code = E_DEPTH_OVF;
                        else                      w_ndepth = r_depth + 1'b1;
                    end
                    C_OP, C_RP: w_code = E_MISSING_OPND;
                    default:    w_code = E_ILLEGAL;
                endcase
            end
            S_NUM, S_CLOSE: begin
                case (w_cls)
                    C_DIG: begin
                        if (r_state == S_CLOSE)   w_code = E_DIG_AFTER_RP;
                        else if (r_dcnt == DIG_MAX) w_code = E_TOO_LONG;
                        else                      w_ndcnt = r_dcnt + 1'b1;
                    end
                    C_OP: w_nstate = S_OPND;
                    C_RP: begin
                        if (r_depth == '0) w_code = E_UNMATCHED_RP;
                        else begin
                            w_ndepth = r_depth - 1'b1;
                            w_nstate = S_CLOSE;
                        end
                    end
                    default: w_code = E_ILLEGAL;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_OPND;
            r_depth <= '0;
            r_dcnt  <= '0;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_err   <= 1'b0;
            r_code  <= E_NONE;
        end else if (restart) begin
            r_state <= S_OPND;
            r_depth <= '0;
            r_dcnt  <= '0;
            r_cnt   <= '0;
            r_pos   <= '0;
            r_err   <= 1'b0;
            r_code  <= E_NONE;
        end else if (in_valid && r_state != S_ERR) begin
            if (w_code != E_NONE) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
                r_code  <= w_code;
                r_pos   <= r_cnt;
            end else begin
                r_state <= w_nstate;
                r_depth <= w_ndepth;
                r_dcnt  <= w_ndcnt;
                if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign out      = (r_state == S_NUM || r_state == S_CLOSE) && (r_depth == '0);
    assign err      = r_err;
    assign err_code = r_code;
    assign err_pos  = r_pos;
    assign depth    = r_depth;
    assign char_cnt = r_cnt;

endmodule

// File: tb/tb_expr_check_n.sv
// Bench for expr_check_n: two instances share one input stream.
//   u0 : defaults (depth 15, 1 digit, no '-' '/', 16-bit positions)
//   u1 : depth 2, 3 digits, '-' '/' enabled, 4-bit positions
module tb_expr_check_n;

    logic       clk = 1'b0;
    logic       clr_n = 1'b0;
    logic       restart = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_ch = 8'h00;

    logic        o0_out, o0_err;
    logic [2:0]  o0_code;
    logic [15:0] o0_pos, o0_cnt;
    logic [3:0]  o0_depth;

    logic        o1_out, o1_err;
    logic [2:0]  o1_code;
    logic [3:0]  o1_pos, o1_cnt;
    logic [1:0]  o1_depth;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    expr_check_n u0 (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
        .out(o0_out), .err(o0_err), .err_code(o0_code), .err_pos(o0_pos),
        .depth(o0_depth), .char_cnt(o0_cnt)
    );

    expr_check_n #(.MAX_DEPTH(2), .MAX_DIGITS(3), .EXT_OPS(1), .POS_W(4)) u1 (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid), .in(in_ch),
        .out(o1_out), .err(o1_err), .err_code(o1_code), .err_pos(o1_pos),
        .depth(o1_depth), .char_cnt(o1_cnt)
    );

    wire [40:0] got0 = {o0_out, o0_err, o0_code, o0_pos, o0_depth, o0_cnt};
    wire [14:0] got1 = {o1_out, o1_err, o1_code, o1_pos, o1_depth, o1_cnt};

    // ---------------- reference model ----------------
    // ctx: what the grammar expects next ("operand", "in number", "after ')'")
    localparam int K_OPND = 0, K_NUM = 1, K_CLOSE = 2;
    int m_maxd[2]   = '{15, 2};
    int m_maxdig[2] = '{1, 3};
    int m_ext[2]    = '{0, 1};
    int m_cmax[2]   = '{65535, 15};
    int m_ctx[2], m_depth[2], m_nd[2], m_cnt[2], m_code[2], m_pos[2];
    bit m_err[2];

    function automatic void mreset();
        for (int k = 0; k < 2; k++) begin
            m_ctx[k] = K_OPND; m_depth[k] = 0; m_nd[k] = 0; m_cnt[k] = 0;
            m_code[k] = 0; m_pos[k] = 0; m_err[k] = 1'b0;
        end
    endfunction

    function automatic void mstep(byte c);
        for (int k = 0; k < 2; k++) begin
            bit dig, op, lp, rp;
            int code, ctx, d, nd;
            if (m_err[k]) continue;
            dig = (c >= "0" && c <= "9");
            op  = (c == "+" || c == "*" || (m_ext[k] != 0 && (c == "-" || c == "/")));
            lp  = (c == "(");
            rp  = (c == ")");
            code = 0; ctx = m_ctx[k]; d = m_depth[k]; nd = m_nd[k];
            if (m_ctx[k] == K_OPND) begin
                if (dig) begin ctx = K_NUM; nd = 1; end
                else if (lp) begin if (d == m_maxd[k]) code = 4; else d++; end
                else if (op || rp) code = 5;
                else code = 1;
            end else begin
                if (dig) begin
                    if (m_ctx[k] == K_CLOSE) code = 6;
                    else if (nd == m_maxdig[k]) code = 2;
                    else nd++;
                end
                else if (op) ctx = K_OPND;
                else if (rp) begin if (d == 0) code = 3; else begin d--; ctx = K_CLOSE; end end
                else code = 1;
            end
            if (code != 0) begin
                m_err[k] = 1'b1; m_code[k] = code; m_pos[k] = m_cnt[k];
            end else begin
                m_ctx[k] = ctx; m_depth[k] = d; m_nd[k] = nd;
                if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
            end
        end
    endfunction

    function automatic bit mout(int k);
        return !m_err[k] && m_ctx[k] != K_OPND && m_depth[k] == 0;
    endfunction

    function automatic logic [40:0] exp0();
        return {mout(0), m_err[0], 3'(m_code[0]), 16'(m_pos[0]), 4'(m_depth[0]), 16'(m_cnt[0])};
    endfunction

    function automatic logic [14:0] exp1();
        return {mout(1), m_err[1], 3'(m_code[1]), 4'(m_pos[1]), 2'(m_depth[1]), 4'(m_cnt[1])};
    endfunction

    // ---------------- drivers ----------------
    task automatic send_char(byte c);
        @(negedge clk);
        in_valid = 1'b1; in_ch = c;
        @(posedge clk); #1;
        in_valid = 1'b0; in_ch = 8'($urandom);
        mstep(c);
    endtask

    task automatic send_str(string s, int gaps);
        for (int i = 0; i < s.len(); i++) begin
            send_char(s[i]);
            if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic do_restart(bit with_valid);
        @(negedge clk);
        restart = 1'b1; in_valid = with_valid; in_ch = "+";
        @(posedge clk); #1;
        restart = 1'b0; in_valid = 1'b0;
        mreset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        n_chk++;
        if (got0 !== 41'd0) begin n_fail++; $display("FAIL reset_u0 got=%h exp=0", got0); end
        n_chk++;
        if (got1 !== 15'd0) begin n_fail++; $display("FAIL reset_u1 got=%h exp=0", got1); end
        @(negedge clk); clr_n = 1'b1;
        mreset();
    endtask

    task automatic test_basic();
        do_restart(1'b0);
        send_str("1+(", 0);
        n_chk++;
        if (o0_out !== 1'b0 || o0_depth !== 4'd1) begin n_fail++;
            $display("FAIL basic_after_lp out=%b depth=%0d exp out=0 depth=1", o0_out, o0_depth); end
        send_str("2*3", 0);
        n_chk++;
        if (o0_out !== 1'b0) begin n_fail++; $display("FAIL basic_after_3 out=%b exp=0", o0_out); end
        send_str(")", 0);
        n_chk++;
        if (o0_out !== 1'b1 || o0_depth !== 4'd0 || o0_cnt !== 16'd7 || o0_err !== 1'b0) begin n_fail++;
            $display("FAIL basic_final out=%b depth=%0d cnt=%0d err=%b exp 1/0/7/0", o0_out, o0_depth, o0_cnt, o0_err); end
    endtask

    task automatic test_digits();
        do_restart(1'b0);
        send_str("123*45", 0);
        n_chk++;
        if (o1_out !== 1'b1 || o1_err !== 1'b0) begin n_fail++;
            $display("FAIL digits_u1_ok out=%b err=%b exp 1/0", o1_out, o1_err); end
        n_chk++;
        if (o0_err !== 1'b1 || o0_code !== 3'd2 || o0_pos !== 16'd1) begin n_fail++;
            $display("FAIL digits_u0_long err=%b code=%0d pos=%0d exp 1/2/1", o0_err, o0_code, o0_pos); end
        do_restart(1'b0);
        send_str("1234", 0);
        n_chk++;
        if (o1_err !== 1'b1 || o1_code !== 3'd2 || o1_pos !== 4'd3 || o1_cnt !== 4'd3) begin n_fail++;
            $display("FAIL digits_u1_long err=%b code=%0d pos=%0d cnt=%0d exp 1/2/3/3", o1_err, o1_code, o1_pos, o1_cnt); end
    endtask

    task automatic test_depth();
        do_restart(1'b0);
        send_str("(((", 0);
        n_chk++;
        if (o1_code !== 3'd4 || o1_pos !== 4'd2 || o1_depth !== 2'd2 || o1_out !== 1'b0) begin n_fail++;
            $display("FAIL depth_ovf code=%0d pos=%0d depth=%0d out=%b exp 4/2/2/0", o1_code, o1_pos, o1_depth, o1_out); end
        n_chk++;
        if (o0_err !== 1'b0 || o0_depth !== 4'd3) begin n_fail++;
            $display("FAIL depth_u0 err=%b depth=%0d exp 0/3", o0_err, o0_depth); end
        do_restart(1'b0);
        send_str("1)", 0);
        n_chk++;
        if (o0_code !== 3'd3 || o0_pos !== 16'd1 || o1_code !== 3'd3 || o1_pos !== 4'd1) begin n_fail++;
            $display("FAIL unmatched_rp code=%0d/%0d pos=%0d/%0d exp 3/1", o0_code, o1_code, o0_pos, o1_pos); end
    endtask

    task automatic test_ext_ops();
        do_restart(1'b0);
        send_str("7-2", 0);
        n_chk++;
        if (o0_code !== 3'd1 || o0_pos !== 16'd1) begin n_fail++;
            $display("FAIL ext_off code=%0d pos=%0d exp 1/1", o0_code, o0_pos); end
        n_chk++;
        if (o1_out !== 1'b1 || o1_err !== 1'b0) begin n_fail++;
            $display("FAIL ext_on out=%b err=%b exp 1/0", o1_out, o1_err); end
    endtask

    task automatic test_errors_gaps();
        do_restart(1'b0);
        send_str("(1)2", 1);
        n_chk++;
        if (o0_code !== 3'd6 || o0_pos !== 16'd3 || o1_code !== 3'd6 || o1_pos !== 4'd3) begin n_fail++;
            $display("FAIL dig_after_rp code=%0d/%0d pos=%0d/%0d exp 6/3", o0_code, o1_code, o0_pos, o1_pos); end
        send_str("+5", 1);   // absorbed by the sticky error
        n_chk++;
        if (o0_code !== 3'd6 || o0_cnt !== 16'd3) begin n_fail++;
            $display("FAIL sticky code=%0d cnt=%0d exp 6/3", o0_code, o0_cnt); end
        do_restart(1'b0);
        send_str("+1", 1);
        n_chk++;
        if (o0_code !== 3'd5 || o0_pos !== 16'd0 || o0_cnt !== 16'd0) begin n_fail++;
            $display("FAIL missing_opnd code=%0d pos=%0d cnt=%0d exp 5/0/0", o0_code, o0_pos, o0_cnt); end
    endtask

    task automatic test_idle_hold();
        do_restart(1'b0);
        send_str("1+(", 0);
        repeat (5) begin @(posedge clk); #1; in_ch = 8'($urandom); end
        n_chk++;
        if (got0 !== exp0() || got1 !== exp1()) begin n_fail++;
            $display("FAIL idle_hold got=%h/%h exp=%h/%h", got0, got1, exp0(), exp1()); end
    endtask

    task automatic test_restart_priority();
        send_str("(", 0);
        do_restart(1'b1);   // in_valid with '+' must be ignored
        n_chk++;
        if (got0 !== 41'd0 || got1 !== 15'd0) begin n_fail++;
            $display("FAIL restart_prio got=%h/%h exp=0", got0, got1); end
    endtask

    task automatic test_saturate();
        do_restart(1'b0);
        send_str("1+1+1+1+1+1+1+1+1", 0);
        n_chk++;
        if (o1_cnt !== 4'd15 || o1_out !== 1'b1 || o0_cnt !== 16'd17 || o0_out !== 1'b1) begin n_fail++;
            $display("FAIL saturate cnt=%0d/%0d out=%b/%b exp 17/15 out 1", o0_cnt, o1_cnt, o0_out, o1_out); end
    endtask

    task automatic test_async_clr();
        do_restart(1'b0);
        send_str("(1+", 0);
        #2 clr_n = 1'b0;
        #1;
        n_chk++;
        if (got0 !== 41'd0 || got1 !== 15'd0) begin n_fail++;
            $display("FAIL async_clr got=%h/%h exp=0", got0, got1); end
        @(negedge clk); clr_n = 1'b1;
        mreset();
        send_str("5", 0);
        n_chk++;
        if (o0_out !== 1'b1 || o0_cnt !== 16'd1 || o0_depth !== 4'd0) begin n_fail++;
            $display("FAIL after_clr out=%b cnt=%0d depth=%0d exp 1/1/0", o0_out, o0_cnt, o0_depth); end
    endtask

    task automatic test_random();
        string alpha = "0123456789+-*/(()) x";
        for (int s = 0; s < 150; s++) begin
            do_restart($urandom_range(0, 1) == 1);
            for (int i = 0; i < int'($urandom_range(1, 22)); i++) begin
                send_char(alpha[$urandom_range(0, alpha.len() - 1)]);
                if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                n_chk++;
                if (got0 !== exp0()) begin n_fail++;
                    $display("FAIL rand_u0 s=%0d i=%0d got=%h exp=%h", s, i, got0, exp0()); end
                n_chk++;
                if (got1 !== exp1()) begin n_fail++;
                    $display("FAIL rand_u1 s=%0d i=%0d got=%h exp=%h", s, i, got1, exp1()); end
            end
        end
    endtask

    initial begin
        mreset();
        test_reset();
        test_basic();
        test_digits();
        test_depth();
        test_ext_ops();
        test_errors_gaps();
        test_idle_hold();
        test_restart_priority();
        test_saturate();
        test_async_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/expr_check_n.md
Name: expr_check_n

Overview:
- Streaming validator for arithmetic-expression strings of digits, operators and parentheses, one ASCII byte per accepted cycle.
- Successor to the single-digit checker. Adds:
  - parametrised operand length and nesting depth
  - optional '-' and '/' operators
  - an input-valid strobe and a synchronous restart
  - a sticky error code with error position
- Sits after the UART/char source in the P1 lab datapath; its outputs feed LEDs and the testbench scoreboard.

Parameters:
- MAX_DEPTH, 15, maximum open-parenthesis nesting (1..255).
- MAX_DIGITS, 1, maximum digits per operand (1..255); 1 gives the single-digit rule.
- EXT_OPS, 0, 1 enables '-' and '/' in addition to '+' and '*'.
- POS_W, 16, width of the character position counter.
- DEPTH_W is a localparam: $clog2(MAX_DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous restart, begins a new string; has priority over in_valid.
- in_valid  in  1  in is consumed on this cycle's rising edge.
- in  in  8  ASCII character.
- out  out  1  the characters consumed so far form a complete, balanced, legal expression.
- err  out  1  sticky error flag.
- err_code  out  3  error cause (see Behaviour).
- err_pos  out  POS_W  0-based index of the offending character.
- depth  out  DEPTH_W  current open-parenthesis count.
- char_cnt  out  POS_W  characters accepted since reset/restart, saturating at all-ones.

Behaviour:
- Reset and restart: clr_n low (async) or restart high (sync) sets:
  - state = S_OPND
  - depth, char_cnt, err_pos, digit count = 0
  - err = 0, err_code = 0
  - out = 0
- Idle: in_valid = 0 holds all state and outputs unchanged.
- Character classes:
  - DIG = '0'..'9'
  - OP = '+' or '*', plus '-' and '/' when EXT_OPS = 1
  - LP = '('
  - RP = ')'
  - anything else is ILL.
- States (2-bit encoding):
  - S_OPND: expecting an operand.
  - S_NUM: inside a number.
  - S_CLOSE: just after ')'.
  - S_ERR: sticky error.
- Transitions on in_valid = 1:
  - From S_OPND:
    - DIG -> S_NUM, digit count = 1.
    - LP -> S_OPND, depth+1. If depth == MAX_DEPTH: S_ERR, code 4.
    - OP or RP -> S_ERR, code 5 (missing operand).
    - ILL -> S_ERR, code 1.
  - From S_NUM:
    - DIG -> stay, digit count+1. If digit count == MAX_DIGITS: S_ERR, code 2.
    - OP -> S_OPND.
    - RP -> S_CLOSE, depth-1. If depth == 0: S_ERR, code 3.
    - LP or ILL -> S_ERR, code 1.
  - From S_CLOSE:
    - OP -> S_OPND.
    - RP -> same rule as RP in S_NUM.
    - DIG -> S_ERR, code 6.
    - LP or ILL -> S_ERR, code 1.
  - S_ERR: absorbs all input until reset or restart.
- On the error cycle:
  - err = 1, err_code latched, err_pos = char_cnt (index of the offending char).
  - char_cnt and depth freeze.
  - The rejected character changes nothing else.
- char_cnt increments on every accepted non-error character and saturates.
- out is registered-state decoded, valid the cycle after the edge that consumed the char: out = (state is S_NUM or S_CLOSE) and depth == 0.
- Error codes: 0 none, 1 illegal/unexpected char, 2 operand too long, 3 unmatched ')', 4 depth overflow, 5 missing operand, 6 digit after ')'. Codes 7 and up are never produced.
- Empty string: out = 0, err = 0.

Decomposition:
- Package expr_pkg holds:
  - state encodings S_OPND/S_NUM/S_CLOSE/S_ERR
  - error-code constants E_NONE..E_DIG_AFTER_RP
  - character-class encoding
- Sub-module char_class (combinational): in, EXT_OPS -> class. Keeps the FSM free of ASCII compares.

Test Plan:
- Default params, stream "1+(2*3)" -> out = 1 after the final ')', depth = 0, char_cnt = 7, err = 0; out = 0 after the '(' and after the '3'.
- MAX_DIGITS = 3, "123*45" -> out = 1. Then restart and send "1234" -> err = 1, err_code = 2, err_pos = 3.
- MAX_DEPTH = 2, "(((" -> err_code = 4, err_pos = 2, depth stays 2. Also "1)" -> err_code = 3, err_pos = 1.
- EXT_OPS = 0, "7-2" -> err_code = 1, err_pos = 1. EXT_OPS = 1, same stream -> out = 1.
- "(1)2" -> err_code = 6, err_pos = 3. "+1" -> err_code = 5, err_pos = 0. Gaps of in_valid = 0 inserted mid-string change nothing.
- clr_n pulsed low asynchronously mid-string "(1+" -> outputs zero immediately, with no clock edge needed. Subsequent "5" -> out = 1, char_cnt = 1.
